// File: rtl/mem_wb_pipe_ctrl.sv
// mem_wb_pipe_ctrl: MEM/WB pipeline registers, load-wait FSM and load-use bubble insertion.
// Define DMEM_TIMEOUT_EN to add a load watchdog that completes a hung load with zero data.
module mem_wb_pipe_ctrl #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_reg_wr,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_wrt_dst,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              flush,
  output logic              dmem_req,
  output logic [DATA_W-1:0] dmem_addr,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic              mem_flag,
  output logic [REG_AW-1:0] mem_wrt_dst,
  output logic [DATA_W-1:0] mem_data,
  output logic              wb_flag,
  output logic [REG_AW-1:0] wb_wrt_dst,
  output logic [DATA_W-1:0] wb_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              ld_err
);

  typedef enum logic {RUN = 1'b0, LD_WAIT = 1'b1} state_t;

  state_t state, state_nxt;

  logic              vld_p1, reg_wr_p1, is_load_p1;
  logic [REG_AW-1:0] dst_p1;
  logic [DATA_W-1:0] res_p1;

  logic              vld_p2, reg_wr_p2;
  logic [REG_AW-1:0] dst_p2;
  logic [DATA_W-1:0] res_p2;

  logic              timeout;
  logic              load_done;
  logic              load_use;
  logic              mem_adv;
  logic              cap_ex;
  logic [DATA_W-1:0] ld_data;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] to_cnt;
  logic             ld_err_q;

  assign timeout = (state == LD_WAIT) && !dmem_rvalid && (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign ld_data = timeout ? '0 : dmem_rdata;
  assign ld_err  = ld_err_q;

  // Counter sits at zero outside LD_WAIT, so every fresh load starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt   <= '0;
      ld_err_q <= 1'b0;
    end else begin
      ld_err_q <= timeout;
      if ((state == LD_WAIT) && !load_done) to_cnt <= to_cnt + CNT_W'(1);
      else                                  to_cnt <= '0;
    end
  end
`else
  assign timeout = 1'b0;
  assign ld_data = dmem_rdata;
  assign ld_err  = 1'b0;
`endif

  assign load_done = (state == LD_WAIT) && (dmem_rvalid || timeout);
  assign load_use  = load_done && ex_valid && (dst_p1 != '0) &&
                     ((dst_p1 == ex_rs) || (dst_p1 == ex_rt));
  assign stall     = ((state == LD_WAIT) && !load_done) || load_use;
  assign mem_adv   = (state == RUN) || load_done;
  assign cap_ex    = !stall && ex_valid && !flush;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (cap_ex && ex_is_load) state_nxt = LD_WAIT;
      LD_WAIT: if (load_done) state_nxt = (cap_ex && ex_is_load) ? LD_WAIT : RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // ---- EX -> MEM (p1): a load-use stall still advances MEM, taking a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      reg_wr_p1  <= 1'b0;
      is_load_p1 <= 1'b0;
      dst_p1     <= '0;
      res_p1     <= '0;
    end else if (mem_adv) begin
      vld_p1     <= cap_ex;
      reg_wr_p1  <= ex_reg_wr;
      is_load_p1 <= ex_is_load;
      dst_p1     <= ex_wrt_dst;
      res_p1     <= ex_result;
    end
  end

  // ---- MEM -> WB (p2): written every cycle, bubble unless MEM advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2    <= 1'b0;
      reg_wr_p2 <= 1'b0;
      dst_p2    <= '0;
      res_p2    <= '0;
    end else begin
      vld_p2 <= mem_adv && vld_p1;
      if (mem_adv) begin
        reg_wr_p2 <= reg_wr_p1;
        dst_p2    <= dst_p1;
        res_p2    <= (state == LD_WAIT) ? ld_data : res_p1;
      end
    end
  end

  assign dmem_req    = (state == LD_WAIT);
  assign dmem_addr   = res_p1;

  assign mem_flag    = vld_p1 && reg_wr_p1 && !is_load_p1 && (dst_p1 != '0);
  assign mem_wrt_dst = dst_p1;
  assign mem_data    = res_p1;

  assign wb_flag     = vld_p2 && reg_wr_p2 && (dst_p2 != '0);
  assign wb_wrt_dst  = dst_p2;
  assign wb_data     = res_p2;

  assign rf_we       = wb_flag;
  assign rf_waddr    = dst_p2;
  assign rf_wdata    = res_p2;

endmodule
